// File: rtl/enlynx_window_ctrl.sv
// Window sequencer and snapshot FIFO for the two-channel enlynx event counter.
// Define ENLYNX_CTRL_TIMESTAMP_EN to tag each snapshot with a free-running 32-bit cycle timestamp.
module enlynx_window_ctrl #(
    parameter int NUM_CNT    = 2,
    parameter int CNT_W      = 32,
    parameter int WIN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic [WIN_W-1:0]         win_len_i,
    input  logic                     cont_i,
    output logic                     busy_o,
    output logic                     err_o,
    output logic                     enable_cnt_o,
    output logic                     eop_o,
    input  logic [NUM_CNT*CNT_W-1:0] counters_i,
    input  logic [NUM_CNT-1:0]       overflow_i,
    output logic                     snap_valid_o,
    input  logic                     snap_ready_i,
    output logic [NUM_CNT*CNT_W-1:0] snap_cnt_o,
    output logic [NUM_CNT-1:0]       snap_ovf_o,
    output logic                     snap_part_o,
    output logic [31:0]              snap_ts_o,
    output logic [7:0]               drop_cnt_o
);
    // state | meaning
    // IDLE  | no window open, waiting for start_i
    // RUN   | window open, enable_cnt_o high, win_cnt counts down to 0
    // EOP   | single end-of-window pulse, counters captured into the FIFO
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_EOP  = 2'd2
    } state_t;

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    state_t                     state_q, state_d;
    logic [WIN_W-1:0]           win_cnt_q, win_cnt_d;
    logic [WIN_W-1:0]           len_q, len_d;
    logic                       cont_q, cont_d;
    logic                       part_q, part_d;
    logic                       err_q, err_d;
    logic [PTR_W:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]             rd_ptr_q, rd_ptr_d;
    logic [7:0]                 drop_q, drop_d;
    logic [NUM_CNT*CNT_W-1:0]   mem_cnt_q [FIFO_DEPTH];
    logic [NUM_CNT*CNT_W-1:0]   mem_cnt_d [FIFO_DEPTH];
    logic [NUM_CNT-1:0]         mem_ovf_q [FIFO_DEPTH];
    logic [NUM_CNT-1:0]         mem_ovf_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]      mem_part_q, mem_part_d;

    logic                       start_ok;
    logic                       win_done;
    logic                       restart;
    logic                       push;
    logic                       pop;
    logic                       wr_en;
    logic                       empty;
    logic                       full;
    logic [PTR_W-1:0]           wr_idx;
    logic [PTR_W-1:0]           head_idx;

    // A simultaneous stop_i suppresses both the start and the error pulse.
    assign start_ok = start_i && !stop_i && (win_len_i != '0);
    assign win_done = (win_cnt_q == '0) || stop_i;
    assign restart  = cont_q && !part_q && !stop_i;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_ok) state_d = ST_RUN;
            ST_RUN:  if (win_done) state_d = ST_EOP;
            ST_EOP:  state_d = restart ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        enable_cnt_o = 1'b0;
        eop_o        = 1'b0;
        busy_o       = 1'b0;
        push         = 1'b0;
        case (state_q)
            ST_RUN: begin
                enable_cnt_o = 1'b1;
                busy_o       = 1'b1;
            end
            ST_EOP: begin
                eop_o  = 1'b1;
                busy_o = 1'b1;
                push   = 1'b1;
            end
            default: ;
        endcase
    end

    // Window timer and latched configuration
    always_comb begin
        win_cnt_d = win_cnt_q;
        len_d     = len_q;
        cont_d    = cont_q;
        part_d    = part_q;
        err_d     = (state_q == ST_IDLE) && start_i && !stop_i && (win_len_i == '0);
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    win_cnt_d = win_len_i - WIN_W'(1);
                    len_d     = win_len_i;
                    cont_d    = cont_i;
                    part_d    = 1'b0;
                end
            end
            ST_RUN: begin
                if (win_done) begin
                    part_d = stop_i;
                end else begin
                    win_cnt_d = win_cnt_q - WIN_W'(1);
                end
            end
            ST_EOP: begin
                if (restart) begin
                    win_cnt_d = len_q - WIN_W'(1);
                    part_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // ---------------- snapshot FIFO ----------------
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop      = !empty && snap_ready_i;
    assign wr_en    = push && (!full || pop);
    assign wr_idx   = wr_ptr_q[PTR_W-1:0];
    // When empty, point at the most recently popped slot so outputs hold their last values.
    assign head_idx = empty ? (rd_ptr_q[PTR_W-1:0] - PTR_W'(1)) : rd_ptr_q[PTR_W-1:0];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        drop_d     = drop_q;
        mem_cnt_d  = mem_cnt_q;
        mem_ovf_d  = mem_ovf_q;
        mem_part_d = mem_part_q;
        if (wr_en) begin
            mem_cnt_d[wr_idx]  = counters_i;
            mem_ovf_d[wr_idx]  = overflow_i;
            mem_part_d[wr_idx] = part_q;
            wr_ptr_d           = wr_ptr_q + (PTR_W+1)'(1);
        end else if (push && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q  <= '0;
            len_q      <= '0;
            cont_q     <= 1'b0;
            part_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            drop_q     <= '0;
            mem_cnt_q  <= '{default: '0};
            mem_ovf_q  <= '{default: '0};
            mem_part_q <= '0;
        end else begin
            win_cnt_q  <= win_cnt_d;
            len_q      <= len_d;
            cont_q     <= cont_d;
            part_q     <= part_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_q     <= drop_d;
            mem_cnt_q  <= mem_cnt_d;
            mem_ovf_q  <= mem_ovf_d;
            mem_part_q <= mem_part_d;
        end
    end

    assign err_o        = err_q;
    assign snap_valid_o = !empty;
    assign snap_cnt_o   = mem_cnt_q[head_idx];
    assign snap_ovf_o   = mem_ovf_q[head_idx];
    assign snap_part_o  = mem_part_q[head_idx];
    assign drop_cnt_o   = drop_q;

`ifdef ENLYNX_CTRL_TIMESTAMP_EN
    logic [31:0] ts_q, ts_d;
    logic [31:0] mem_ts_q [FIFO_DEPTH];
    logic [31:0] mem_ts_d [FIFO_DEPTH];

    always_comb begin
        ts_d     = ts_q + 32'd1;
        mem_ts_d = mem_ts_q;
        if (wr_en) begin
            mem_ts_d[wr_idx] = ts_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q     <= '0;
            mem_ts_q <= '{default: '0};
        end else begin
            ts_q     <= ts_d;
            mem_ts_q <= mem_ts_d;
        end
    end

    assign snap_ts_o = mem_ts_q[head_idx];
`else
    assign snap_ts_o = '0;
`endif

endmodule

// File: tb/tb_enlynx_window_ctrl.sv
// Self-checking bench for enlynx_window_ctrl: window-level reference model plus snapshot scoreboard.
`timescale 1ns/1ps
module tb_enlynx_window_ctrl;
    localparam int NUM_CNT    = 2;
    localparam int CNT_W      = 32;
    localparam int WIN_W      = 16;
    localparam int FIFO_DEPTH = 4;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     start_i = 1'b0;
    logic                     stop_i = 1'b0;
    logic [WIN_W-1:0]         win_len_i = '0;
    logic                     cont_i = 1'b0;
    logic                     busy_o;
    logic                     err_o;
    logic                     enable_cnt_o;
    logic                     eop_o;
    logic [NUM_CNT*CNT_W-1:0] counters_i = '0;
    logic [NUM_CNT-1:0]       overflow_i = '0;
    logic                     snap_valid_o;
    logic                     snap_ready_i = 1'b0;
    logic [NUM_CNT*CNT_W-1:0] snap_cnt_o;
    logic [NUM_CNT-1:0]       snap_ovf_o;
    logic                     snap_part_o;
    logic [31:0]              snap_ts_o;
    logic [7:0]               drop_cnt_o;

    enlynx_window_ctrl #(
        .NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .WIN_W(WIN_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i),
        .win_len_i(win_len_i), .cont_i(cont_i), .busy_o(busy_o), .err_o(err_o),
        .enable_cnt_o(enable_cnt_o), .eop_o(eop_o), .counters_i(counters_i),
        .overflow_i(overflow_i), .snap_valid_o(snap_valid_o), .snap_ready_i(snap_ready_i),
        .snap_cnt_o(snap_cnt_o), .snap_ovf_o(snap_ovf_o), .snap_part_o(snap_part_o),
        .snap_ts_o(snap_ts_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] cnt;
        logic [1:0]  ovf;
        logic        part;
        logic [31:0] ts;
    } snap_t;

    snap_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: windows tracked by the absolute cycle of their end pulse.
    longint cyc = 0;
    longint m_eop_at = 0;
    longint m_err_at = -1;
    bit     m_busy = 0, m_cont = 0, m_part = 0;
    int     m_len = 0, m_occ = 0, m_drop = 0;
    logic [31:0] m_ts = '0;
    bit     exp_en = 0, exp_eop = 0, exp_busy = 0, exp_err = 0, exp_valid = 0;
    int     exp_drop = 0;

    always @(posedge clk) begin
        bit    pop, push;
        snap_t e;
        if (!rst_n) begin
            m_busy = 0; m_cont = 0; m_part = 0; m_len = 0;
            m_occ = 0; m_drop = 0; m_ts = '0; m_err_at = -1;
            exp_q.delete();
        end else begin
            pop  = (m_occ > 0) && snap_ready_i;
            push = 0;
            e    = '{cnt: '0, ovf: '0, part: 1'b0, ts: '0};
            if (!m_busy) begin
                if (start_i && !stop_i) begin
                    if (win_len_i == 0) begin
                        m_err_at = cyc + 1;
                    end else begin
                        m_busy   = 1;
                        m_len    = int'(win_len_i);
                        m_cont   = cont_i;
                        m_part   = 0;
                        m_eop_at = cyc + m_len + 1;
                    end
                end
            end else if (cyc < m_eop_at) begin
                if (stop_i) begin
                    m_eop_at = cyc + 1;
                    m_part   = 1;
                end
            end else begin
                push   = 1;
                e.cnt  = counters_i;
                e.ovf  = overflow_i;
                e.part = m_part;
`ifdef ENLYNX_CTRL_TIMESTAMP_EN
                e.ts   = m_ts;
`endif
                if (m_cont && !m_part && !stop_i) m_eop_at = cyc + m_len + 1;
                else m_busy = 0;
            end
            if (push) begin
                if (m_occ == FIFO_DEPTH && !pop) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    exp_q.push_back(e);
                    m_occ++;
                end
            end
            if (pop) m_occ--;
            m_ts = m_ts + 32'd1;
        end
        cyc++;
        exp_busy  = m_busy;
        exp_en    = m_busy && (cyc < m_eop_at);
        exp_eop   = m_busy && (cyc == m_eop_at);
        exp_err   = (m_err_at == cyc);
        exp_valid = (m_occ > 0);
        exp_drop  = m_drop;
    end

    // Monitor: control outputs every cycle, snapshot scoreboard on each accepted entry.
    logic [63:0] last_cnt = '0;
    logic [1:0]  last_ovf = '0;
    logic        last_part = 1'b0;
    logic [31:0] last_ts = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_enable", enable_cnt_o, 0);
            chk("rst_eop", eop_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_err", err_o, 0);
            chk("rst_valid", snap_valid_o, 0);
            chk("rst_drop", drop_cnt_o, 0);
            last_cnt = '0; last_ovf = '0; last_part = 1'b0; last_ts = '0;
        end else begin
            chk("enable", enable_cnt_o, exp_en);
            chk("eop", eop_o, exp_eop);
            chk("busy", busy_o, exp_busy);
            chk("err", err_o, exp_err);
            chk("valid", snap_valid_o, exp_valid);
            chk("drop", drop_cnt_o, exp_drop);
            if (snap_valid_o) begin
                if (snap_ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL snap_unexpected: got entry cnt=%0h expected none at %0t", snap_cnt_o, $time);
                    end else begin
                        chk("snap_cnt", snap_cnt_o, exp_q[0].cnt);
                        chk("snap_ovf", snap_ovf_o, exp_q[0].ovf);
                        chk("snap_part", snap_part_o, exp_q[0].part);
                        chk("snap_ts", snap_ts_o, exp_q[0].ts);
                        last_cnt  = exp_q[0].cnt;
                        last_ovf  = exp_q[0].ovf;
                        last_part = exp_q[0].part;
                        last_ts   = exp_q[0].ts;
                        exp_q.pop_front();
                    end
                end
            end else begin
                chk("hold_cnt", snap_cnt_o, last_cnt);
                chk("hold_ovf", snap_ovf_o, last_ovf);
                chk("hold_part", snap_part_o, last_part);
                chk("hold_ts", snap_ts_o, last_ts);
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
        counters_i = {$urandom(), $urandom()};
        overflow_i = 2'($urandom_range(0, 3));
    endtask

    task automatic pulse_start(input int len, input bit cont);
        start_i   = 1'b1;
        win_len_i = WIN_W'(len);
        cont_i    = cont;
        next();
        start_i   = 1'b0;
    endtask

    initial begin
        repeat (3) next();
        rst_n = 1'b1;
        next();

        // single window of 10 cycles
        snap_ready_i = 1'b1;
        pulse_start(10, 0);
        repeat (14) next();

        // auto-restart, stop in the 2nd cycle of the 3rd window
        pulse_start(5, 1);
        repeat (13) next();
        stop_i = 1'b1;
        next();
        stop_i = 1'b0;
        repeat (10) next();

        // back-to-back 1-cycle windows into a stalled FIFO until drops saturate
        snap_ready_i = 1'b0;
        pulse_start(1, 1);
        repeat (600) next();
        chk("drop_saturated", drop_cnt_o, 255);
        stop_i = 1'b1;
        next();
        stop_i = 1'b0;
        repeat (4) next();
        snap_ready_i = 1'b1;
        repeat (8) next();

        // zero length raises err only; start together with stop is ignored
        pulse_start(0, 0);
        repeat (4) next();
        stop_i = 1'b1;
        pulse_start(5, 0);
        stop_i = 1'b0;
        repeat (4) next();

        // asynchronous reset in the middle of a window
        snap_ready_i = 1'b0;
        pulse_start(2, 0);
        repeat (3) next();
        pulse_start(20, 0);
        repeat (6) next();
        #3 rst_n = 1'b0;
        #0.5;
        chk("async_rst_enable", enable_cnt_o, 0);
        chk("async_rst_eop", eop_o, 0);
        chk("async_rst_valid", snap_valid_o, 0);
        repeat (2) next();
        rst_n = 1'b1;
        next();
        snap_ready_i = 1'b1;
        pulse_start(3, 0);
        repeat (8) next();

        // stall then release during back-to-back windows: full FIFO with simultaneous push and pop
        snap_ready_i = 1'b0;
        pulse_start(1, 1);
        repeat (12) next();
        snap_ready_i = 1'b1;
        repeat (12) next();
        stop_i = 1'b1;
        next();
        stop_i = 1'b0;
        repeat (6) next();

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            start_i      = ($urandom_range(0, 9) == 0);
            win_len_i    = ($urandom_range(0, 15) == 0) ? '0 : WIN_W'($urandom_range(1, 6));
            cont_i       = 1'($urandom_range(0, 1));
            stop_i       = ($urandom_range(0, 19) == 0);
            snap_ready_i = ($urandom_range(0, 3) != 0);
            next();
        end
        start_i = 1'b0;
        stop_i  = 1'b1;
        next();
        stop_i       = 1'b0;
        snap_ready_i = 1'b1;
        repeat (30) next();
        chk("drained", 64'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
